// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : alu_op_sequencer
// Brief   : Queues ALU requests and drives them one at a time onto a
//           combinational ALU, returning sampled results over valid/ready.
// Revision: 1.0
// ============================================================================
module alu_op_sequencer #(
    parameter int DEPTH         = 4,
    parameter int SETTLE_CYCLES = 2,
    parameter int TAG_W         = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [63:0]      req_a,
    input  logic [63:0]      req_b,
    input  logic [3:0]       req_opcode,
    input  logic [TAG_W-1:0] req_tag,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [63:0]      rsp_result,
    output logic             rsp_exception,
    output logic             rsp_error,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [63:0]      alu_a_out,
    output logic [63:0]      alu_b_out,
    output logic [3:0]       alu_opcode_out,
    input  logic [63:0]      alu_result_in,
    input  logic             alu_exception_in,
    input  logic             alu_error_in,
    output logic             busy,
    output logic [15:0]      ops_count,
    output logic [7:0]       err_count
);
    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;
    localparam int c_SW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [c_CW-1:0] c_FULL   = c_CW'(DEPTH);
    localparam logic [c_SW-1:0] c_SETTLE = c_SW'(SETTLE_CYCLES);
    localparam logic [c_SW-1:0] c_ONE    = c_SW'(1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    logic [63:0]      r_mem_a   [DEPTH];
    logic [63:0]      r_mem_b   [DEPTH];
    logic [3:0]       r_mem_op  [DEPTH];
    logic [TAG_W-1:0] r_mem_tag [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_CW-1:0]  r_count;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [c_SW-1:0]  r_cnt;
    logic [63:0]      r_alu_a;
    logic [63:0]      r_alu_b;
    logic [3:0]       r_alu_op;
    logic [TAG_W-1:0] r_tag;
    logic             r_rsp_valid;
    logic [63:0]      r_rsp_result;
    logic             r_rsp_exception;
    logic             r_rsp_error;
    logic [15:0]      r_ops_count;
    logic [7:0]       r_err_count;

    logic w_push;
    logic w_pop;
    logic w_capture;
    logic w_accept;
    logic w_busy;

    // Ready looks only at the registered count: a full FIFO never accepts.
    assign req_ready = (r_count != c_FULL);
    assign w_push    = req_valid & req_ready;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_a[r_wr_ptr]   <= req_a;
            r_mem_b[r_wr_ptr]   <= req_b;
            r_mem_op[r_wr_ptr]  <= req_opcode;
            r_mem_tag[r_wr_ptr] <= req_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (r_count != '0) w_state_nxt = S_SETTLE;
            S_SETTLE: if (r_cnt == c_ONE) w_state_nxt = S_RESP;
            S_RESP:   if (r_rsp_valid && rsp_ready) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_pop     = (r_state == S_IDLE) && (r_count != '0);
        w_capture = (r_state == S_SETTLE) && (r_cnt == c_ONE);
        w_accept  = (r_state == S_RESP) && r_rsp_valid && rsp_ready;
        w_busy    = (r_state != S_IDLE) || (r_count != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt           <= '0;
            r_alu_a         <= '0;
            r_alu_b         <= '0;
            r_alu_op        <= '0;
            r_tag           <= '0;
            r_rsp_valid     <= 1'b0;
            r_rsp_result    <= '0;
            r_rsp_exception <= 1'b0;
            r_rsp_error     <= 1'b0;
            r_ops_count     <= '0;
            r_err_count     <= '0;
        end else begin
            if (w_pop) begin
                r_alu_a  <= r_mem_a[r_rd_ptr];
                r_alu_b  <= r_mem_b[r_rd_ptr];
                r_alu_op <= r_mem_op[r_rd_ptr];
                r_tag    <= r_mem_tag[r_rd_ptr];
                r_cnt    <= c_SETTLE;
            end
            if (r_state == S_SETTLE) r_cnt <= r_cnt - c_ONE;
            if (w_capture) begin
                r_rsp_result    <= alu_result_in;
                r_rsp_exception <= alu_exception_in;
                r_rsp_error     <= alu_error_in;
                r_rsp_valid     <= 1'b1;
            end
            if (w_accept) begin
                r_rsp_valid <= 1'b0;
                r_ops_count <= r_ops_count + 16'd1;
                if (r_rsp_error && (r_err_count != 8'hFF))
                    r_err_count <= r_err_count + 8'd1;
            end
        end
    end

    assign rsp_valid      = r_rsp_valid;
    assign rsp_result     = r_rsp_result;
    assign rsp_exception  = r_rsp_exception;
    assign rsp_error      = r_rsp_error;
    assign rsp_tag        = r_tag;
    assign alu_a_out      = r_alu_a;
    assign alu_b_out      = r_alu_b;
    assign alu_opcode_out = r_alu_op;
    assign busy           = w_busy;
    assign ops_count      = r_ops_count;
    assign err_count      = r_err_count;
endmodule
`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_alu_op_sequencer
// Brief   : Directed and randomized checks of alu_op_sequencer against a
//           transaction-level model with a stand-in combinational ALU.
// Revision: 1.0
// ============================================================================
module tb_alu_op_sequencer;
    localparam int DEPTH  = 4;
    localparam int SETTLE = 2;
    localparam int TAG_W  = 4;

    typedef struct packed {
        logic [63:0]      a;
        logic [63:0]      b;
        logic [3:0]       op;
        logic [TAG_W-1:0] tag;
    } req_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [63:0]      req_a = '0;
    logic [63:0]      req_b = '0;
    logic [3:0]       req_opcode = '0;
    logic [TAG_W-1:0] req_tag = '0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [63:0]      rsp_result;
    logic             rsp_exception;
    logic             rsp_error;
    logic [TAG_W-1:0] rsp_tag;
    logic [63:0]      alu_a_out;
    logic [63:0]      alu_b_out;
    logic [3:0]       alu_opcode_out;
    logic [63:0]      alu_result_in;
    logic             alu_exception_in;
    logic             alu_error_in;
    logic             busy;
    logic [15:0]      ops_count;
    logic [7:0]       err_count;

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    alu_op_sequencer #(.DEPTH(DEPTH), .SETTLE_CYCLES(SETTLE), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_opcode(req_opcode), .req_tag(req_tag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_exception(rsp_exception), .rsp_error(rsp_error), .rsp_tag(rsp_tag),
        .alu_a_out(alu_a_out), .alu_b_out(alu_b_out), .alu_opcode_out(alu_opcode_out),
        .alu_result_in(alu_result_in), .alu_exception_in(alu_exception_in),
        .alu_error_in(alu_error_in),
        .busy(busy), .ops_count(ops_count), .err_count(err_count)
    );

    // Stand-in ALU: {error, exception, result}. Divide by +/-0 flags error.
    function automatic logic [65:0] alu_fn(input logic [63:0] a, input logic [63:0] b,
                                           input logic [3:0] op);
        logic [63:0] r;
        logic        e;
        logic        er;
        e  = 1'b0;
        er = 1'b0;
        case (op)
            4'd0: r = $realtobits($bitstoreal(a) + $bitstoreal(b));
            4'd3: begin
                er = (b[62:0] == 63'd0);
                r  = er ? 64'd0 : (a - b);
            end
            default: begin
                r = a ^ {b[31:0], b[63:32]} ^ {60'd0, op};
                e = r[0];
            end
        endcase
        return {er, e, r};
    endfunction

    logic [65:0] alu_bus;
    always_comb alu_bus = alu_fn(alu_a_out, alu_b_out, alu_opcode_out);
    assign alu_result_in    = alu_bus[63:0];
    assign alu_exception_in = alu_bus[64];
    assign alu_error_in     = alu_bus[65];

    // Inputs as seen at the rising edge, replayed into the model at the next falling edge.
    logic s_rst, s_valid, s_rready;
    req_t s_req;
    always @(posedge clk) begin
        s_rst    <= rst;
        s_valid  <= req_valid;
        s_rready <= rsp_ready;
        s_req    <= '{a: req_a, b: req_b, op: req_opcode, tag: req_tag};
    end

    req_t        m_q[$];
    req_t        m_cur;
    bit          m_inflight;
    bit          m_pushed;
    int          m_timer;
    bit          m_rv;
    logic [63:0] m_res;
    logic        m_exc;
    logic        m_err;
    logic [15:0] m_ops;
    logic [7:0]  m_errs;

    task automatic model_step();
        bit do_push;
        if (s_rst !== 1'b0) begin
            m_q.delete();
            m_cur = '0; m_inflight = 0; m_pushed = 0; m_timer = 0; m_rv = 0;
            m_res = '0; m_exc = 0; m_err = 0; m_ops = '0; m_errs = '0;
        end else begin
            do_push = s_valid && (m_q.size() < DEPTH);
            if (!m_inflight) begin
                if (m_q.size() > 0) begin
                    m_cur = m_q.pop_front();
                    m_inflight = 1;
                    m_timer = SETTLE;
                end
            end else if (!m_rv) begin
                m_timer--;
                if (m_timer == 0) begin
                    {m_err, m_exc, m_res} = alu_fn(m_cur.a, m_cur.b, m_cur.op);
                    m_rv = 1;
                end
            end else if (s_rready) begin
                m_rv = 0;
                m_inflight = 0;
                m_ops++;
                if (m_err && m_errs != 8'hFF) m_errs++;
            end
            if (do_push) m_q.push_back(s_req);
            m_pushed = do_push;
        end
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tmo(input string nm);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: timed out at %0t", nm, $time);
    endtask

    always @(negedge clk) begin
        model_step();
        if (chk_en) begin
            chk("req_ready", req_ready, m_q.size() < DEPTH);
            chk("rsp_valid", rsp_valid, m_rv);
            chk("rsp_result", rsp_result, m_res);
            chk("rsp_exception", rsp_exception, m_exc);
            chk("rsp_error", rsp_error, m_err);
            chk("rsp_tag", rsp_tag, m_cur.tag);
            chk("alu_a_out", alu_a_out, m_cur.a);
            chk("alu_b_out", alu_b_out, m_cur.b);
            chk("alu_opcode_out", alu_opcode_out, m_cur.op);
            chk("busy", busy, m_inflight || (m_q.size() != 0));
            chk("ops_count", ops_count, m_ops);
            chk("err_count", err_count, m_errs);
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
        step(); step();
        rst = 1'b0;
    endtask

    task automatic push_one(input logic [63:0] a, input logic [63:0] b,
                            input logic [3:0] op, input logic [TAG_W-1:0] tag);
        bit ok = 0;
        req_valid = 1'b1; req_a = a; req_b = b; req_opcode = op; req_tag = tag;
        for (int k = 0; k < 100; k++) begin
            step();
            if (m_pushed) begin ok = 1; break; end
        end
        if (!ok) tmo("push");
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int k = 0; k < 200; k++) begin
            if (!m_inflight && m_q.size() == 0) begin ok = 1; break; end
            step();
        end
        if (!ok) tmo("idle");
    endtask

    task automatic run_op(input logic [63:0] a, input logic [63:0] b,
                          input logic [3:0] op, input logic [TAG_W-1:0] tag);
        push_one(a, b, op, tag);
        wait_idle();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [TAG_W-1:0] got[$];
        bit ok;
        logic [63:0] a, b;
        logic [3:0]  op;

        // Reset state
        step(); step();
        chk_en = 1'b1;
        chk("reset_req_ready", req_ready, 1'b1);
        chk("reset_rsp_valid", rsp_valid, 1'b0);
        chk("reset_alu_a", alu_a_out, 64'd0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_ops", ops_count, 16'd0);
        chk("reset_errs", err_count, 8'd0);
        rst = 1'b0;

        // Single add: 2.0 + 3.0, tag 5
        push_one(64'h4000000000000000, 64'h4008000000000000, 4'd0, 4'd5);
        step(); chk("lat_e1", rsp_valid, 1'b0);
        step(); chk("lat_e2", rsp_valid, 1'b0);
        step(); chk("lat_e3", rsp_valid, 1'b1);
        chk("add_result", rsp_result, 64'h4014000000000000);
        chk("add_tag", rsp_tag, 4'd5);
        chk("add_alu_a", alu_a_out, 64'h4000000000000000);
        rsp_ready = 1'b1;
        step(); chk("add_done", rsp_valid, 1'b0);
        chk("add_ops", ops_count, 16'd1);

        // Backpressure: 1 in flight + 4 queued, tag 5 retried
        do_reset();
        for (int t = 0; t < 5; t++)
            push_one({32'd0, $urandom}, {32'd0, $urandom}, 4'd1, TAG_W'(t));
        req_valid = 1'b1; req_tag = 4'd5; req_opcode = 4'd2;
        step();
        chk("bp_full", req_ready, 1'b0);
        chk("bp_head_tag", rsp_tag, 4'd0);
        repeat (10) step();
        chk("bp_still_full", req_ready, 1'b0);
        rsp_ready = 1'b1;
        ok = 0;
        for (int k = 0; k < 200; k++) begin
            if (rsp_valid) got.push_back(rsp_tag);
            if (m_pushed) req_valid = 1'b0;
            if (got.size() == 6) begin ok = 1; break; end
            step();
        end
        req_valid = 1'b0;
        if (!ok) tmo("bp_collect");
        for (int i = 0; i < got.size(); i++) chk("bp_order", got[i], TAG_W'(i));
        step();

        // Error path and err_count saturation
        do_reset();
        push_one(64'h4000000000000000, 64'h0, 4'd3, 4'd1);
        ok = 0;
        for (int k = 0; k < 20; k++) begin
            if (rsp_valid) begin ok = 1; break; end
            step();
        end
        if (!ok) tmo("err_rsp");
        chk("err_flag", rsp_error, 1'b1);
        rsp_ready = 1'b1;
        step(); chk("err_cnt1", err_count, 8'd1);
        for (int i = 0; i < 254; i++)
            run_op({$urandom, $urandom}, (i % 2) ? 64'h8000000000000000 : 64'h0, 4'd3, TAG_W'(i));
        chk("err_cnt_ff", err_count, 8'hFF);
        run_op(64'h1, 64'h0, 4'd3, 4'd2);
        chk("err_cnt_sat", err_count, 8'hFF);
        chk("err_ops", ops_count, 16'd256);
        run_op(64'h10, 64'h3, 4'd3, 4'd3);
        chk("div_ok_err", rsp_error, 1'b0);

        // Reset mid-operation with 3 requests queued
        do_reset();
        for (int t = 0; t < 4; t++)
            push_one({$urandom, $urandom}, {$urandom, $urandom}, 4'd1, TAG_W'(t));
        rsp_ready = 1'b1;
        push_one(64'h5, 64'h6, 4'd2, 4'd4);
        step();
        rst = 1'b1; rsp_ready = 1'b0;
        step();
        rst = 1'b0;
        chk("mid_busy", busy, 1'b0);
        chk("mid_ops", ops_count, 16'd0);
        chk("mid_rsp", rsp_valid, 1'b0);
        chk("mid_ready", req_ready, 1'b1);
        rsp_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            chk("mid_quiet", rsp_valid, 1'b0);
        end

        // ops_count wrap
        do_reset();
        #1;
        force dut.r_ops_count = 16'hFFFF;
        #1;
        release dut.r_ops_count;
        m_ops = 16'hFFFF;
        step();
        chk("wrap_pre", ops_count, 16'hFFFF);
        rsp_ready = 1'b1;
        run_op(64'h3, 64'h4, 4'd5, 4'd9);
        chk("wrap_post", ops_count, 16'h0000);

        // Push and pop on the same edge with DEPTH-1 entries queued
        do_reset();
        for (int t = 0; t < 4; t++)
            push_one({$urandom, $urandom}, {$urandom, $urandom}, 4'd4, TAG_W'(t));
        rsp_ready = 1'b1;
        step();
        push_one(64'h77, 64'h88, 4'd6, 4'd4);
        chk("conc_ready", req_ready, 1'b1);
        wait_idle();
        chk("conc_ops", ops_count, 16'd5);

        // Randomized traffic
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rst       = ($urandom_range(0, 599) == 0);
            req_valid = $urandom_range(0, 1);
            a  = {$urandom, $urandom};
            b  = {$urandom, $urandom};
            op = 4'($urandom_range(0, 5));
            if (op == 4'd3 && $urandom_range(0, 1) == 1) b = {$urandom_range(0, 1) == 1, 63'd0};
            req_a = a; req_b = b; req_opcode = op; req_tag = TAG_W'($urandom);
            rsp_ready = ($urandom_range(0, 9) < 7);
            step();
        end
        rst = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
        wait_idle();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
